scan_chain_seq: RTL and testbench
=================================

Name: scan_chain_seq

Overview:
- Scan-chain load/capture/unload sequencer; drives SE and SI of one chain of scan flops (sdffrnq cells, chain RN tied high) and consumes the chain's serial output SO.
- Accepts parallel test patterns, shifts them in, pulses a functional capture, then shifts the captured response out into a parallel register.
- Sits between the on-chip test controller (pattern/response streams) and the scan-flop chain.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain (N); must be ≥2.
- CAP_CYCLES, 1, capture cycles with SE=0; must be ≥1.

Ports:
- CLK  in  1  clock; chain flops share this clock.
- RST  in  1  synchronous reset, active-high.
- PAT_VALID  in  1  pattern offered.
- PAT_READY  out  1  pattern accepted when PAT_VALID & PAT_READY at a CLK rising edge.
- PAT_DATA  in  CHAIN_LEN  pattern; bit i lands in chain cell i (cell 0 = SI end).
- FLUSH  in  1  level; unload the parked response with zero fill when no pattern is pending.
- RSP_VALID  out  1  response held.
- RSP_READY  in  1  response consumed when RSP_VALID & RSP_READY.
- RSP_DATA  out  CHAIN_LEN  captured response; bit i = cell i.
- SE  out  1  scan enable to the chain.
- SI  out  1  scan input to chain cell 0.
- SO  in  1  Q of chain cell N-1.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; SE=0, SI=0, PAT_READY=0 while RST=1, RSP_VALID=0, RSP_DATA=0, all counters 0, the unload flag cleared. Reset mid-operation aborts immediately; a partial response is discarded.
- State IDLE:
  - SE=0, SI=0, PAT_READY=1.
  - On accept -> LOAD with unload flag=0.
  - FLUSH is ignored in IDLE.
- State LOAD (N cycles):
  - SE=1.
  - In cycle k (k=0..N-1), SI = PAT_DATA[N-1-k], held in an internal copy taken at accept.
  - If unload flag=1, SO is sampled each cycle into a shift register: sh <= {sh[N-2:0], SO}.
  - At the last edge, sh goes to RSP_DATA and RSP_VALID is set. -> CAPTURE.
- State CAPTURE (CAP_CYCLES cycles):
  - SE=0, SI=0.
  - In the last cycle, eligibility = (RSP_VALID=0 or RSP_READY=1).
  - If eligible and PAT_VALID: PAT_READY=1, accept -> LOAD with unload flag=1.
  - Else if eligible and FLUSH -> UNLOAD.
  - Else -> PARK with rot=0.
- State PARK (chain recirculates to preserve the captured data):
  - SE=1, SI=SO; rot <= (rot+1) mod N on every PARK cycle.
  - Exit is allowed only in a cycle with rot=N-1, so the chain is realigned after the edge.
  - Same eligibility and priority as CAPTURE: PAT -> LOAD (unload=1), else FLUSH -> UNLOAD, else stay.
  - PAT_READY=1 only in an exit-eligible cycle.
- State UNLOAD (N cycles):
  - SE=1, SI=0; SO is shifted into sh as in LOAD.
  - At the last edge: RSP_DATA<=sh, RSP_VALID=1. -> IDLE.
- Response handshake:
  - RSP_VALID clears on RSP_READY.
  - A response load is never started while RSP_VALID=1 and RSP_READY=0, so a held response is never overwritten.
  - A consume and a new load may start in the same cycle.
- Priority: PAT_VALID beats FLUSH; RST beats everything.
- Counters: shift counter width clog2(N); it wraps to 0 on every state exit.
- Latency: pattern accept -> first capture = N+1 edges later (CAP_CYCLES=1). Response valid N edges after a load or unload starts.
- SE never toggles mid-LOAD or mid-UNLOAD; no stall exists inside those states.

Optional Feature:
- SCAN_CHAIN_SEQ_PARITY_EN defined: adds output RSP_PAR (1 bit).
  - RSP_PAR is the XOR of all N response bits, accumulated serially during shift.
  - It is registered with RSP_DATA and valid whenever RSP_VALID=1; reset value 0.
- Not defined: RSP_PAR port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then a basic cycle (N=4, chain model = 4 scan flops, functional D = ~Q).
  - Pattern 4'b1010 accepted.
  - Expect SI sequence 1,0,1,0 (MSB first) with SE=1 for 4 cycles, then SE=0 for 1 cycle.
  - FLUSH=1 -> UNLOAD; expect RSP_DATA=4'b0101, RSP_VALID=1, BUSY=0 after.
- Back-to-back patterns 4'b0011 then 4'b1100.
  - Expect the second LOAD to start the cycle after CAPTURE with no PARK.
  - Expect RSP_DATA=4'b1100 at the end of the second LOAD (inverse of 0011).
- Response stall: hold RSP_READY=0 with a response pending.
  - Expect PARK to rotate; exit only at rot=N-1 edges, i.e. PARK length a multiple of 4.
  - After release, the unloaded response equals the pre-park capture exactly.
- Simultaneous PAT_VALID and FLUSH in an eligible cycle: expect LOAD, not UNLOAD.
- RST pulsed in LOAD cycle 2: expect the next cycle SE=0, SI=0, RSP_VALID=0, BUSY=0, PAT_READY=1 one cycle after RST drops.
- With SCAN_CHAIN_SEQ_PARITY_EN: response 4'b0111 -> RSP_PAR=1; response 4'b0101 -> RSP_PAR=0.

Source files
------------

// File: rtl/scan_chain_seq.sv
// scan_chain_seq: load/capture/unload sequencer for a single scan-flop chain.
// Parallel patterns are shifted in MSB first. A functional capture of CAP_CYCLES
// cycles follows. The captured response is shifted out into RSP_DATA, either
// while the next pattern loads or by a zero-fill unload when FLUSH is set.
// Optional build macro SCAN_CHAIN_SEQ_PARITY_EN adds the RSP_PAR output, which
// is the XOR of the response bits.
module scan_chain_seq #(
  parameter int CHAIN_LEN  = 16,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAT_VALID,
  output logic                 PAT_READY,
  input  logic [CHAIN_LEN-1:0] PAT_DATA,
  input  logic                 FLUSH,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [CHAIN_LEN-1:0] RSP_DATA,
`ifdef SCAN_CHAIN_SEQ_PARITY_EN
  output logic                 RSP_PAR,
`endif
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam int CAP_W = (CAP_CYCLES > 1) ? $clog2(CAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_W-1:0] LAST_CAP = CAP_W'(CAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_PARK    = 3'd3,
    S_UNLOAD  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;       // shift position in LOAD/UNLOAD
  logic [CAP_W-1:0]       cap_q, cap_d;       // capture cycle index
  logic [CNT_W-1:0]       rot_q, rot_d;       // chain rotation while parked
  logic                   unload_q, unload_d; // LOAD also shifts a response out
  logic [CHAIN_LEN-1:0]   pat_q, pat_d;       // pattern copy, MSB is next SI bit
  logic [CHAIN_LEN-2:0]   sh_q, sh_d;         // response bits collected so far
  logic [CHAIN_LEN-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;

  logic                   shift_last;
  logic                   cap_last;
  logic                   rot_last;
  logic                   eligible;
  logic                   decide;
  logic                   accept;
  logic                   sample;
  logic                   rsp_load;
  logic [CHAIN_LEN-1:0]   sh_full;

  assign shift_last = (cnt_q == LAST_BIT);
  assign cap_last   = (cap_q == LAST_CAP);
  assign rot_last   = (rot_q == LAST_BIT);
  // A new response may be started only if the held one is gone or leaving now.
  assign eligible   = !rsp_valid_q || RSP_READY;
  // Exit point of CAPTURE/PARK; PARK leaves only with the chain realigned.
  assign decide     = eligible &&
                      (((state_q == S_CAPTURE) && cap_last) ||
                       ((state_q == S_PARK) && rot_last));
  assign accept     = PAT_VALID && PAT_READY;
  assign sample     = ((state_q == S_LOAD) && unload_q) || (state_q == S_UNLOAD);
  assign sh_full    = {sh_q, SO};
  assign rsp_load   = sample && shift_last;

  assign BUSY       = (state_q != S_IDLE);
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_DATA   = rsp_data_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pattern wins over FLUSH at every exit point
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (shift_last) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_last) begin
          if (accept)               state_d = S_LOAD;
          else if (decide && FLUSH) state_d = S_UNLOAD;
          else                      state_d = S_PARK;
        end
      end
      S_PARK: begin
        if (accept)               state_d = S_LOAD;
        else if (decide && FLUSH) state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (shift_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Chain drive and pattern handshake; reset forces everything quiet
  always_comb begin
    SE        = 1'b0;
    SI        = 1'b0;
    PAT_READY = 1'b0;
    case (state_q)
      S_IDLE:    PAT_READY = 1'b1;
      S_LOAD: begin
        SE = 1'b1;
        SI = pat_q[CHAIN_LEN-1];
      end
      S_CAPTURE: PAT_READY = decide;
      S_PARK: begin
        SE        = 1'b1;
        SI        = SO;       // recirculate so the capture survives
        PAT_READY = decide;
      end
      S_UNLOAD:  SE = 1'b1;   // zero fill behind the outgoing response
      default: ;
    endcase
    if (RST) begin
      SE        = 1'b0;
      SI        = 1'b0;
      PAT_READY = 1'b0;
    end
  end

  // Counters, pattern shifter and response collection
  always_comb begin
    cnt_d       = '0;
    cap_d       = '0;
    rot_d       = '0;
    pat_d       = pat_q;
    unload_d    = unload_q;
    sh_d        = sh_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;

    if (((state_q == S_LOAD) || (state_q == S_UNLOAD)) && !shift_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == S_CAPTURE) && !cap_last) begin
      cap_d = cap_q + CAP_W'(1);
    end
    if ((state_q == S_PARK) && !rot_last) begin
      rot_d = rot_q + CNT_W'(1);
    end

    if (accept) begin
      pat_d    = PAT_DATA;
      unload_d = (state_q != S_IDLE);
    end else if (state_q == S_LOAD) begin
      pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
    end

    if (sample) begin
      sh_d = sh_full[CHAIN_LEN-2:0];
    end

    if (RSP_READY) begin
      rsp_valid_d = 1'b0;
    end
    if (rsp_load) begin
      rsp_data_d  = sh_full;
      rsp_valid_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      cap_q       <= '0;
      rot_q       <= '0;
      unload_q    <= 1'b0;
      pat_q       <= '0;
      sh_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      rot_q       <= rot_d;
      unload_q    <= unload_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SCAN_CHAIN_SEQ_PARITY_EN
  logic par_q, par_d;
  logic rsp_par_q, rsp_par_d;

  assign RSP_PAR = rsp_par_q;

  // Serial parity of the outgoing bits, published alongside RSP_DATA
  always_comb begin
    par_d     = par_q;
    rsp_par_d = rsp_par_q;
    if (sample) begin
      par_d = par_q ^ SO;
    end
    if (rsp_load) begin
      rsp_par_d = par_q ^ SO;
      par_d     = 1'b0;
    end
  end

  // Parity registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q     <= 1'b0;
      rsp_par_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      rsp_par_q <= rsp_par_d;
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_seq.sv
// tb_scan_chain_seq: bench for scan_chain_seq with a 4-flop chain whose
// functional next state is the inverse of each flop, so every pattern p
// captures ~p. The expected responses are kept in a FIFO of ~pattern values.
`timescale 1ns/1ps
module tb_scan_chain_seq;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PAT_VALID;
  logic         PAT_READY;
  logic [N-1:0] PAT_DATA;
  logic         FLUSH;
  logic         RSP_VALID;
  logic         RSP_READY;
  logic [N-1:0] RSP_DATA;
  logic         SE;
  logic         SI;
  logic         SO;
  logic         BUSY;
`ifdef SCAN_CHAIN_SEQ_PARITY_EN
  logic         RSP_PAR;
`endif

  logic [N-1:0] chain = '0;
  logic [N-1:0] exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] rsp;
    logic         par;
  } vec_t;
  vec_t vecs[5];

  always #5 CLK = ~CLK;

  scan_chain_seq #(.CHAIN_LEN(N), .CAP_CYCLES(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PAT_VALID (PAT_VALID),
    .PAT_READY (PAT_READY),
    .PAT_DATA  (PAT_DATA),
    .FLUSH     (FLUSH),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
`ifdef SCAN_CHAIN_SEQ_PARITY_EN
    .RSP_PAR   (RSP_PAR),
`endif
    .SE        (SE),
    .SI        (SI),
    .SO        (SO),
    .BUSY      (BUSY)
  );

  // Scan chain: shift when SE=1, functional capture D = ~Q otherwise.
  assign SO = chain[N-1];
  always @(posedge CLK) begin
    if (SE) chain <= {chain[N-2:0], SI};
    else    chain <= ~chain;
  end

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic checkn(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // One clock: scoreboard the handshakes about to happen, then advance to the next negedge.
  task automatic step();
    logic [N-1:0] e;
    #1;
    if (RST) begin
      exp_q.delete();
    end else begin
      if (RSP_VALID && RSP_READY) begin
        check1("sb_rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkn("sb_rsp_data", RSP_DATA, e);
`ifdef SCAN_CHAIN_SEQ_PARITY_EN
          check1("sb_rsp_par", RSP_PAR, ^e);
`endif
          $display("rsp consumed %b expected %b", RSP_DATA, e);
        end
      end
      if (PAT_VALID && PAT_READY) begin
        exp_q.push_back(~PAT_DATA);
        $display("pat accepted %b", PAT_DATA);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Load one pattern from IDLE, capture, flush it out and consume the response.
  task automatic run_vec(input vec_t v);
    logic [N-1:0] p;
    p = v.pat;
    PAT_VALID = 1'b1;
    PAT_DATA  = p;
    #1;
    check1("idle_pat_ready", PAT_READY, 1'b1);
    step();
    PAT_VALID = 1'b0;
    PAT_DATA  = N'($urandom);
    for (int k = 0; k < N; k++) begin
      #1;
      check1("load_se", SE, 1'b1);
      check1("load_si", SI, p[N-1-k]);
      step();
    end
    FLUSH = 1'b1;
    #1;
    check1("cap_se", SE, 1'b0);
    check1("cap_si", SI, 1'b0);
    step();
    FLUSH = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      check1("unl_se", SE, 1'b1);
      check1("unl_si", SI, 1'b0);
      check1("unl_busy", BUSY, 1'b1);
      step();
    end
    #1;
    check1("vec_rsp_valid", RSP_VALID, 1'b1);
    checkn("vec_rsp_data", RSP_DATA, v.rsp);
    check1("vec_busy", BUSY, 1'b0);
`ifdef SCAN_CHAIN_SEQ_PARITY_EN
    check1("vec_rsp_par", RSP_PAR, v.par);
`endif
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    #1;
    check1("vec_rsp_cleared", RSP_VALID, 1'b0);
  endtask

  initial begin
    vecs[0] = '{pat: 4'b1010, rsp: 4'b0101, par: 1'b0};
    vecs[1] = '{pat: 4'b1000, rsp: 4'b0111, par: 1'b1};
    vecs[2] = '{pat: 4'b0011, rsp: 4'b1100, par: 1'b0};
    vecs[3] = '{pat: 4'b1111, rsp: 4'b0000, par: 1'b0};
    vecs[4] = '{pat: 4'b0001, rsp: 4'b1110, par: 1'b1};

    RST = 1'b1; PAT_VALID = 1'b0; PAT_DATA = '0; FLUSH = 1'b0; RSP_READY = 1'b0;
    @(negedge CLK);
    #1;
    check1("rst_se", SE, 1'b0);
    check1("rst_si", SI, 1'b0);
    check1("rst_pat_ready", PAT_READY, 1'b0);
    check1("rst_rsp_valid", RSP_VALID, 1'b0);
    checkn("rst_rsp_data", RSP_DATA, 4'b0000);
    check1("rst_busy", BUSY, 1'b0);
    step();
    RST = 1'b0;
    #1;
    check1("idle_ready_after_rst", PAT_READY, 1'b1);

    // Table: single pattern then flush
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back patterns, then a stalled response forces PARK
    PAT_VALID = 1'b1; PAT_DATA = 4'b0011;
    step();
    PAT_VALID = 1'b0;
    repeat (N) step();
    PAT_VALID = 1'b1; PAT_DATA = 4'b1100;
    #1;
    check1("b2b_cap_ready", PAT_READY, 1'b1);
    check1("b2b_cap_se", SE, 1'b0);
    step();
    PAT_VALID = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      check1("b2b_load_se", SE, 1'b1);
      check1("b2b_load_si", SI, (k < 2));
      step();
    end
    #1;
    check1("b2b_rsp_valid", RSP_VALID, 1'b1);
    checkn("b2b_rsp_data", RSP_DATA, 4'b1100);
    FLUSH = 1'b1;
    #1;
    check1("stall_cap_ready", PAT_READY, 1'b0);
    step();
    for (int c = 0; c < 8; c++) begin
      RSP_READY = (c == 6);
      #1;
      check1("park_se", SE, 1'b1);
      check1("park_si_recirc", SI, SO);
      check1("park_busy", BUSY, 1'b1);
      check1("park_pat_ready", PAT_READY, (c == 7));
      step();
    end
    RSP_READY = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      check1("park_unl_si", SI, 1'b0);
      check1("park_unl_valid", RSP_VALID, 1'b0);
      step();
    end
    FLUSH = 1'b0;
    #1;
    check1("park_rsp_valid", RSP_VALID, 1'b1);
    checkn("park_rsp_data", RSP_DATA, 4'b0011);
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;

    // PAT_VALID and FLUSH together at an eligible capture: LOAD wins
    PAT_VALID = 1'b1; PAT_DATA = 4'b0110;
    step();
    PAT_VALID = 1'b0;
    repeat (N) step();
    PAT_VALID = 1'b1; PAT_DATA = 4'b1001; FLUSH = 1'b1;
    #1;
    check1("prio_ready", PAT_READY, 1'b1);
    step();
    PAT_VALID = 1'b0; FLUSH = 1'b0;
    #1;
    check1("prio_se", SE, 1'b1);
    check1("prio_si", SI, 1'b1);
    repeat (N) step();
    #1;
    check1("prio_rsp_valid", RSP_VALID, 1'b1);
    checkn("prio_rsp_data", RSP_DATA, 4'b1001);

    // Consume and load in one cycle, then reset in LOAD cycle 2
    RSP_READY = 1'b1; PAT_VALID = 1'b1; PAT_DATA = N'($urandom);
    #1;
    check1("cons_load_ready", PAT_READY, 1'b1);
    step();
    RSP_READY = 1'b0; PAT_VALID = 1'b0;
    repeat (2) step();
    RST = 1'b1;
    #1;
    check1("rst_mid_se", SE, 1'b0);
    check1("rst_mid_ready", PAT_READY, 1'b0);
    step();
    RST = 1'b0;
    #1;
    check1("post_rst_se", SE, 1'b0);
    check1("post_rst_si", SI, 1'b0);
    check1("post_rst_valid", RSP_VALID, 1'b0);
    checkn("post_rst_data", RSP_DATA, 4'b0000);
    check1("post_rst_busy", BUSY, 1'b0);
    check1("post_rst_ready", PAT_READY, 1'b1);
    repeat (N + 2) step();
    #1;
    check1("post_rst_quiet_valid", RSP_VALID, 1'b0);
    check1("post_rst_quiet_busy", BUSY, 1'b0);

    // Random traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      PAT_VALID = 1'($urandom_range(0, 1));
      PAT_DATA  = N'($urandom);
      FLUSH     = ($urandom_range(0, 3) == 0);
      RSP_READY = 1'($urandom_range(0, 1));
      step();
    end
    PAT_VALID = 1'b0; FLUSH = 1'b1; RSP_READY = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (exp_q.size() == 0 && !BUSY && !RSP_VALID) break;
      step();
    end
    #1;
    check1("drain_queue_empty", exp_q.size() == 0, 1'b1);
    check1("drain_idle", BUSY, 1'b0);
    check1("drain_no_rsp", RSP_VALID, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
